// File: rtl/trivium_stream_xor.sv
// ---------------------------------------------------------------------------
// trivium_stream_xor
// Gathers W keystream bits from an upstream trivium generator, one request
// per cycle, and XORs the assembled key word onto a plaintext word.
//
// State table
//   state   | meaning
//   FILL    | requesting and collecting keystream bits into ks_buf
//   KEY_RDY | W bits held; waiting for a plaintext word to fire
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   ks_en             request to the generator (answered the next cycle)
//   ks_bit, ks_valid  generator answer; ks_valid=0 marks a warm-up bit
//   in_data/valid/ready    plaintext handshake
//   out_data/valid/ready   ciphertext handshake
//   word_count        number of words emitted, wraps at 16 bits
// ---------------------------------------------------------------------------
module trivium_stream_xor #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  output logic         ks_en,
  input  logic         ks_bit,
  input  logic         ks_valid,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [15:0]  word_count
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic {FILL, KEY_RDY} state_t;

  state_t        state;
  logic [CW-1:0] ks_cnt;
  logic [W-1:0]  ks_buf;
  logic          pending;
  // Held low through reset and released on the first edge afterwards, so
  // ks_en stays quiet while rst is asserted.
  logic          armed;
  logic [CW:0]   need;
  logic          accept;
  logic          fire;

  // Bits already held plus the one still in flight; requesting only while
  // this is below W means the generator is never asked for a spare bit.
  assign need     = {1'b0, ks_cnt} + {{CW{1'b0}}, pending};
  assign ks_en    = armed && (state == FILL) && (need < (CW+1)'(W));
  assign in_ready = (state == KEY_RDY) && (!out_valid || out_ready);
  assign fire     = in_valid && in_ready;
  assign accept   = pending && ks_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FILL;
      ks_cnt     <= '0;
      ks_buf     <= '0;
      pending    <= 1'b0;
      armed      <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      word_count <= '0;
    end else begin
      armed   <= 1'b1;
      pending <= ks_en;

      case (state)
        FILL: begin
          // A warm-up answer (ks_valid=0) is simply dropped; ks_en re-asks.
          if (accept) begin
            for (int i = 0; i < W; i++) begin
              if (ks_cnt == CW'(i)) ks_buf[i] <= ks_bit;
            end
            ks_cnt <= ks_cnt + CW'(1);
            if (ks_cnt == CW'(W - 1)) state <= KEY_RDY;
          end
        end
        KEY_RDY: begin
          if (fire) begin
            ks_cnt <= '0;
            state  <= FILL;
          end
        end
        default: state <= FILL;
      endcase

      // Output register is tracked independently of the fill state; a fire
      // with out_ready=1 replaces the word without a bubble.
      if (fire) begin
        out_data   <= in_data ^ ks_buf;
        out_valid  <= 1'b1;
        word_count <= word_count + 16'd1;
      end else if (out_ready) begin
        out_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/trivium_stream_xor.md
TRIVIUM_STREAM_XOR -- requirements
Module: trivium_stream_xor

Interface
REQ-001 Parameter W, default 8, data/keystream word width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 ks_en  output  1  enable to the upstream trivium generator; one request per cycle high.
REQ-005 ks_bit  input  1  keystream bit from the generator, registered there, valid the cycle after the ks_en request.
REQ-006 ks_valid  input  1  high when ks_bit is post-warm-up keystream; low marks a warm-up bit that SHALL be discarded.
REQ-007 in_data  input  W  plaintext word.
REQ-008 in_valid  input  1  plaintext word present.
REQ-009 in_ready  output  1  block accepts in_data this cycle.
REQ-010 out_data  output  W  ciphertext word, which is in_data XOR keystream word.
REQ-011 out_valid  output  1  out_data valid.
REQ-012 out_ready  input  1  downstream accepts out_data.
REQ-013 word_count  output  16  count of words emitted; wraps from 0xFFFF to 0x0000.

Function
REQ-014 States: FILL (gathering keystream), KEY_RDY (W bits held).
- Encoding is free.
- Output register occupancy (out_valid) SHALL be tracked independently of the state.
REQ-015 pending SHALL equal ks_en registered; a request issued in cycle N SHALL be answered in cycle N+1.
REQ-016 ks_en SHALL be high iff state is FILL and (ks_cnt + pending) < W.
- This never over-requests.
- ks_en SHALL be low in KEY_RDY.
REQ-017 In a cycle with pending=1 and ks_valid=1, ks_bit SHALL be stored at bit position ks_cnt of ks_buf, and ks_cnt SHALL increment.
- The first accepted bit goes to the LSB.
REQ-018 In a cycle with pending=1 and ks_valid=0, the bit SHALL be dropped and ks_cnt SHALL be unchanged; ks_en re-requests automatically.
REQ-019 ks_bit SHALL be ignored when pending=0.
REQ-020 FILL transitions to KEY_RDY on the edge at which ks_cnt reaches W.
REQ-021 in_ready = (state==KEY_RDY) and (!out_valid or out_ready); this is combinational and SHALL not depend on in_valid.
REQ-022 Fire = in_valid and in_ready. On fire:
- out_data <= in_data ^ ks_buf
- out_valid <= 1
- word_count <= word_count+1 (mod 2^16)
- ks_cnt <= 0
- state <= FILL
REQ-023 Without a fire, out_valid SHALL clear on out_ready=1 and SHALL hold otherwise.
- out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-024 A simultaneous fire and out_ready=1 SHALL replace the output word with no bubble; out_valid stays 1.
REQ-025 Latency: fire in cycle N gives out_valid=1 in cycle N+1.
REQ-026 Refill after a fire takes at least W+1 cycles; the first ks_en is in cycle N+1.
REQ-027 Keystream bits SHALL be used exactly once, in order; no bit is skipped or reused across words.
REQ-028 in_valid is not required to stay asserted; the block SHALL not latch in_data except on fire.

Reset
REQ-029 On rst=1, asynchronously and independent of clk:
- state=FILL
- ks_cnt=0, ks_buf=0, pending=0
- ks_en=0 until the first edge after release
- in_ready=0
- out_valid=0, out_data=0
- word_count=0
REQ-030 Reset asserted mid-fill or with out_valid=1 SHALL discard all held keystream and output.
- After release, ks_en SHALL assert on the first clock edge.
- Generator resynchronisation is the integrator's responsibility.

Verification
REQ-031 Basic encrypt: ks_valid=1 always, ks bits 1,0,1,1,0,0,1,0 (W=8), then in_data=0xFF with in_valid=1 -> out_data=0xB2 one cycle after fire, word_count=1.
REQ-032 Warm-up discard: ks_valid=0 for the first 5 answered requests, then bits as in REQ-031 -> identical out_data=0xB2, and exactly 13 ks_en request cycles before KEY_RDY.
REQ-033 Backpressure: out_ready=0 with out_valid=1 and a second key word ready -> in_ready=0 and out_data held; raising out_ready with in_valid=1 -> the new word appears the next cycle with no gap.
REQ-034 Request bound: any random ks_valid pattern -> the number of ks_en cycles minus the number of accepted bits equals the number of dropped bits, and ks_cnt never exceeds W.
REQ-035 Reset mid-fill: assert rst after 4 accepted bits -> all outputs zero immediately; after release, a fresh 8-bit fill is required before in_ready=1.
REQ-036 Counter wrap: preload by 65535 fires, one more fire -> word_count=0x0000.
